// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcodes and prefetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStall,
    StDrain,
    StHalted
  } ipq_state_e;

  // Opcode lives in the top five bits of the instruction word.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 5] == OP_HALT;
  endfunction

endpackage

// File: rtl/ipq_fifo.sv
// Synchronous FIFO for the prefetch queue; flush empties it on the clock edge.
// The head entry is read straight from registered storage.
module ipq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Storage, pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a small FIFO and presents the head to the CPU. Handles redirects, a
// HALT opcode and a global enable.
// Optional feature macro: IPQ_NOP_FILL_EN (an empty queue presents a NOP bubble).
module instr_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] i_datain,
  output logic [ADDR_W-1:0]  i_pc,
  output logic               i_valid,
  input  logic               i_ready,
  output logic               halted
);

`ifdef IPQ_NOP_FILL_EN
  localparam bit NopFill = 1'b1;
`else
  localparam bit NopFill = 1'b0;
`endif

  localparam int unsigned EntW = INSTR_W + ADDR_W;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

  ipq_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  fetch_q, fetch_d;     // next address to request
  logic               discard_q, discard_d; // in-flight ack belongs to a flushed stream
  logic               halted_q, halted_d;
  logic [INSTR_W-1:0] last_data_q;
  logic [ADDR_W-1:0]  last_pc_q;

  logic [EntW-1:0]    head;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc;
  logic [CntW-1:0]    count;
  logic               empty;

  logic               steer, ack_ok, push, fifo_pop, flush;
  logic [ADDR_W-1:0]  steer_addr, addr_next;

  assign {head_data, head_pc} = head;

  // Start outside IDLE behaves as a redirect to 0; redirect takes priority.
  assign steer      = (redirect | start) & (state_q != StIdle);
  assign steer_addr = redirect ? redirect_addr : '0;
  assign ack_ok     = req_q & imem_ack;
  assign addr_next  = addr_q + ADDR_W'(1);
  assign push       = enable & ack_ok & ~discard_q & ~steer & (state_q == StFetch);
  assign fifo_pop   = enable & i_valid & i_ready & ~empty & ~steer;
  assign flush      = enable & steer;

  ipq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({imem_data, addr_q}),
    .pop       (fifo_pop),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  // State register and registered handshake outputs; everything holds while enable is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      addr_q      <= '0;
      fetch_q     <= '0;
      discard_q   <= 1'b0;
      halted_q    <= 1'b0;
      last_data_q <= '0;
      last_pc_q   <= '0;
    end else if (enable) begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      fetch_q     <= fetch_d;
      discard_q   <= discard_d;
      halted_q    <= halted_d;
      last_data_q <= i_datain;
      last_pc_q   <= i_pc;
    end
  end

  // Next-state and fetch bookkeeping.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    fetch_d   = fetch_q;
    discard_d = discard_q;
    halted_d  = halted_q;
    if (state_q == StIdle) begin
      if (start) begin
        state_d   = StFetch;
        req_d     = 1'b1;
        addr_d    = '0;
        fetch_d   = '0;
        discard_d = 1'b0;
      end
    end else if (steer) begin
      state_d  = StFetch;
      fetch_d  = steer_addr;
      halted_d = 1'b0;
      if (req_q && !imem_ack) begin
        // Old request still owns the bus; let it finish and drop its data.
        discard_d = 1'b1;
      end else begin
        req_d     = 1'b1;
        addr_d    = steer_addr;
        discard_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              addr_d    = fetch_q;
            end else begin
              fetch_d = addr_next;
              if (is_halt(imem_data)) begin
                state_d = StDrain;
                req_d   = 1'b0;
              end else if (count == CntLast && !fifo_pop) begin
                state_d = StStall;
                req_d   = 1'b0;
              end else begin
                addr_d = addr_next;
              end
            end
          end
        end
        StStall: begin
          if (fifo_pop) begin
            state_d = StFetch;
            req_d   = 1'b1;
            addr_d  = fetch_q;
          end
        end
        StDrain: begin
          if (fifo_pop && is_halt(head_data)) begin
            state_d  = StHalted;
            halted_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // CPU-facing outputs: queue head, optional NOP bubble, else the last shown value.
  always_comb begin
    i_valid  = 1'b0;
    i_datain = last_data_q;
    i_pc     = last_pc_q;
    if (state_q != StHalted && !empty) begin
      i_valid  = 1'b1;
      i_datain = head_data;
      i_pc     = head_pc;
    end else if (NopFill && state_q != StIdle && state_q != StHalted) begin
      i_valid  = 1'b1;
      i_datain = {OP_NOP, (INSTR_W-5)'(0)};
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (DEPTH=4, ADDR_W=8).
module tb_instr_prefetch_queue;

`ifdef IPQ_NOP_FILL_EN
  localparam bit NopFill = 1'b1;
`else
  localparam bit NopFill = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, enable, start, redirect, imem_ack, i_ready;
  logic [7:0]  redirect_addr;
  logic [15:0] imem_data;
  logic        imem_req, i_valid, halted;
  logic [7:0]  imem_addr, i_pc;
  logic [15:0] i_datain;

  int checks = 0;
  int errors = 0;

  instr_prefetch_queue #(
    .DEPTH  (4),
    .ADDR_W (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .i_datain      (i_datain),
    .i_pc          (i_pc),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st, rd;
    logic [7:0]  ra;
    logic        ack;
    logic [15:0] dat;
    logic        rdy, en;
    logic        x_req;
    logic [7:0]  x_addr;
    logic        x_val;
    logic [15:0] x_din;
    logic [7:0]  x_pc;
    logic        x_halt;
    logic        bub;  // queue empty while active: NOP bubble when that feature is built in
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic st, logic rd, logic [7:0] ra, logic ack, logic [15:0] dat,
                             logic rdy, logic en, logic xr, logic [7:0] xa, logic xv,
                             logic [15:0] xd, logic [7:0] xp, logic xh, logic bub);
    vec_t r;
    r.st = st; r.rd = rd; r.ra = ra; r.ack = ack; r.dat = dat; r.rdy = rdy; r.en = en;
    r.x_req = xr; r.x_addr = xa; r.x_val = xv; r.x_din = xd; r.x_pc = xp; r.x_halt = xh;
    r.bub = bub;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; redirect = 0; redirect_addr = 8'h00; imem_ack = 0; imem_data = 16'h0000;
    i_ready = 0; enable = 1;
  endtask

  initial begin
    // st rd ra ack dat rdy en | req addr val din pc halt bub
    vecs.push_back(v(1, 0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1234, 1, 1, 1, 8'h01, 1, 16'h1234, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h5678, 1, 1, 1, 8'h02, 1, 16'h5678, 8'h01, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 8'h02, 0, 16'h5678, 8'h01, 0, 1));
    // start mid-stream with a request in flight: its ack is dropped
    vecs.push_back(v(1, 0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h02, 0, 16'h5678, 8'h01, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'hDEAD, 0, 1, 1, 8'h00, 0, 16'h5678, 8'h01, 0, 1));
    // fill to DEPTH with i_ready low
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1000, 0, 1, 1, 8'h01, 1, 16'h1000, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1001, 0, 1, 1, 8'h02, 1, 16'h1000, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1002, 0, 1, 1, 8'h03, 1, 16'h1000, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1003, 0, 1, 0, 8'h03, 1, 16'h1000, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h9999, 0, 1, 0, 8'h03, 1, 16'h1000, 8'h00, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 8'h04, 1, 16'h1001, 8'h01, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1004, 0, 1, 0, 8'h04, 1, 16'h1001, 8'h01, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 8'h05, 1, 16'h1002, 8'h02, 0, 0));
    // redirect to 0x40 coinciding with an ack
    vecs.push_back(v(0, 1, 8'h40, 1, 16'h7777, 0, 1, 1, 8'h40, 0, 16'h1002, 8'h02, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h4040, 0, 1, 1, 8'h41, 1, 16'h4040, 8'h40, 0, 0));
    // redirect to 2 with request in flight, then HALT at address 3
    vecs.push_back(v(0, 1, 8'h02, 0, 16'h0000, 0, 1, 1, 8'h41, 0, 16'h4040, 8'h40, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'hBEEF, 0, 1, 1, 8'h02, 0, 16'h4040, 8'h40, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h2002, 0, 1, 1, 8'h03, 1, 16'h2002, 8'h02, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h0800, 0, 1, 0, 8'h03, 1, 16'h2002, 8'h02, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h03, 1, 16'h2002, 8'h02, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 0, 8'h03, 1, 16'h0800, 8'h03, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 0, 8'h03, 0, 16'h0800, 8'h03, 1, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h1111, 1, 1, 0, 8'h03, 0, 16'h0800, 8'h03, 1, 0));
    // redirect out of HALTED to 0xFF; next request wraps to 0x00
    vecs.push_back(v(0, 1, 8'hFF, 0, 16'h0000, 0, 1, 1, 8'hFF, 0, 16'h0800, 8'h03, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h00FF, 0, 1, 1, 8'h00, 1, 16'h00FF, 8'hFF, 0, 0));
    // enable low for 5 cycles: everything frozen despite start/ack/ready
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(1, 0, 8'h00, 1, 16'h1111, 1, 0, 1, 8'h00, 1, 16'h00FF, 8'hFF, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 8'h00, 0, 16'h00FF, 8'hFF, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 8'h00, 0, 16'h00FF, 8'hFF, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'hAAAA, 0, 1, 1, 8'h01, 1, 16'hAAAA, 8'h00, 0, 0));

    // Reset with a stray ack present
    idle_inputs();
    reset = 0; imem_ack = 1; imem_data = 16'hFFFF;
    tick(); tick();
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_valid", i_valid, 0);
    chk("reset_datain", i_datain, 0);
    chk("reset_pc", i_pc, 0);
    chk("reset_halted", halted, 0);
    idle_inputs();
    reset = 1;
    tick();
    chk("idle_req", imem_req, 0);

    foreach (vecs[i]) begin
      start = vecs[i].st; redirect = vecs[i].rd; redirect_addr = vecs[i].ra;
      imem_ack = vecs[i].ack; imem_data = vecs[i].dat; i_ready = vecs[i].rdy;
      enable = vecs[i].en;
      tick();
      chk($sformatf("v%0d_req", i), imem_req, vecs[i].x_req);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].x_addr);
      chk($sformatf("v%0d_valid", i), i_valid, (NopFill && vecs[i].bub) ? 1'b1 : vecs[i].x_val);
      chk($sformatf("v%0d_datain", i), i_datain,
          (NopFill && vecs[i].bub) ? 16'h0000 : vecs[i].x_din);
      chk($sformatf("v%0d_pc", i), i_pc, vecs[i].x_pc);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].x_halt);
    end

    // Reset mid-transaction, late ack afterwards must be ignored
    idle_inputs();
    reset = 0; imem_ack = 1; imem_data = 16'h0800;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_valid", i_valid, 0);
    chk("async_rst_addr", imem_addr, 0);
    chk("async_rst_datain", i_datain, 0);
    tick();
    reset = 1;
    tick();
    chk("late_ack_req", imem_req, 0);
    chk("late_ack_valid", i_valid, 0);
    chk("late_ack_halted", halted, 0);
    imem_ack = 0; start = 1;
    tick();
    start = 0;
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    imem_ack = 1; imem_data = 16'h1234;
    tick();
    chk("restart_valid", i_valid, 1);
    chk("restart_datain", i_datain, 16'h1234);
    chk("restart_pc", i_pc, 0);
    chk("restart_addr1", imem_addr, 1);

    // Redirect has priority over start
    start = 1; redirect = 1; redirect_addr = 8'h10; imem_ack = 1; imem_data = 16'h5555;
    tick();
    start = 0; redirect = 0;
    chk("prio_addr", imem_addr, 8'h10);
    chk("prio_req", imem_req, 1);
    chk("prio_valid", i_valid, NopFill);
    imem_data = 16'h10AA;
    tick();
    chk("prio_pc", i_pc, 8'h10);
    chk("prio_datain", i_datain, 16'h10AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
